// File: rtl/ex_muldiv_pkg.sv
// Shared op codes, FSM states and request context for the EX-stage multiply/divide unit.
// Signed codes are accepted only when MULDIV_SIGNED_EN is defined.
package ex_muldiv_pkg;

   localparam int unsigned XLEN_DEFAULT  = 32;
   localparam int unsigned CNT_W_DEFAULT = 6;
   localparam int unsigned OP_W          = 5;
   localparam int unsigned RD_W          = 5;

   localparam logic [OP_W-1:0] OP_MUL   = 5'h10;
   localparam logic [OP_W-1:0] OP_MULHU = 5'h11;
   localparam logic [OP_W-1:0] OP_DIVU  = 5'h12;
   localparam logic [OP_W-1:0] OP_REMU  = 5'h13;
   localparam logic [OP_W-1:0] OP_MULH  = 5'h14;
   localparam logic [OP_W-1:0] OP_DIV   = 5'h15;
   localparam logic [OP_W-1:0] OP_REM   = 5'h16;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_BUSY = 2'd1,
      ST_DONE = 2'd2
   } state_e;

   // Operation context held for the whole iteration.
   typedef struct packed {
      logic [OP_W-1:0] op;
      logic [RD_W-1:0] rd;
      logic            neg_q;
      logic            neg_r;
   } muldiv_ctx_t;

   function automatic logic op_supported(input logic [OP_W-1:0] op);
`ifdef MULDIV_SIGNED_EN
      return op inside {OP_MUL, OP_MULHU, OP_DIVU, OP_REMU, OP_MULH, OP_DIV, OP_REM};
`else
      return op inside {OP_MUL, OP_MULHU, OP_DIVU, OP_REMU};
`endif
   endfunction

   function automatic logic op_is_div(input logic [OP_W-1:0] op);
      return op inside {OP_DIVU, OP_REMU, OP_DIV, OP_REM};
   endfunction

   function automatic logic op_is_signed(input logic [OP_W-1:0] op);
      return op inside {OP_MULH, OP_DIV, OP_REM};
   endfunction

   // Result comes from the upper half of the working register.
   function automatic logic op_takes_high(input logic [OP_W-1:0] op);
      return op inside {OP_MULHU, OP_MULH, OP_REMU, OP_REM};
   endfunction

endpackage

// File: rtl/ex_muldiv_if.sv
// Request/result handshake between the ID/EX pipeline and the multiply/divide unit.
interface ex_muldiv_if #(parameter int unsigned XLEN = ex_muldiv_pkg::XLEN_DEFAULT);

   logic            in_valid;
   logic            in_ready;
   logic [XLEN-1:0] data_1;
   logic [XLEN-1:0] data_2;
   logic [4:0]      RD;
   logic [4:0]      ALU_Control;
   logic            flush;
   logic            stall;
   logic            out_valid;
   logic            out_ready;
   logic [XLEN-1:0] out_result;
   logic [4:0]      out_RD;

   modport master (
      output in_valid, data_1, data_2, RD, ALU_Control, flush, out_ready,
      input  in_ready, stall, out_valid, out_result, out_RD
   );

   modport slave (
      input  in_valid, data_1, data_2, RD, ALU_Control, flush, out_ready,
      output in_ready, stall, out_valid, out_result, out_RD
   );

endinterface

// File: rtl/ex_muldiv_iter.sv
// One iteration step: shift-add multiply or restoring divide on the 2*XLEN working register.
module muldiv_iter #(
   parameter int unsigned XLEN = 32
) (
   input  logic              is_div,
   input  logic [XLEN-1:0]   opnd,
   input  logic [2*XLEN-1:0] work,
   output logic [2*XLEN-1:0] work_nxt_c
);

   logic [XLEN:0] sum;
   logic [XLEN:0] trial;
   logic [XLEN:0] diff;

   // Multiply keeps the carry in the top bit; divide restores when the trial borrows.
   always_comb begin
      sum   = {1'b0, work[2*XLEN-1:XLEN]} + (work[0] ? {1'b0, opnd} : '0);
      trial = {work[2*XLEN-1:XLEN], work[XLEN-1]};
      diff  = trial - {1'b0, opnd};
      if (is_div) begin
         if (diff[XLEN]) work_nxt_c = {trial[XLEN-1:0], work[XLEN-2:0], 1'b0};
         else            work_nxt_c = {diff[XLEN-1:0],  work[XLEN-2:0], 1'b1};
      end else begin
         work_nxt_c = {sum, work[XLEN-1:1]};
      end
   end

endmodule

// File: rtl/ex_muldiv.sv
// Multi-cycle multiply/divide unit in EX; stalls decode while iterating.
// Define MULDIV_SIGNED_EN to add MULH/DIV/REM.
module ex_muldiv
   import ex_muldiv_pkg::*;
#(
   parameter int unsigned XLEN  = XLEN_DEFAULT,
   parameter int unsigned CNT_W = CNT_W_DEFAULT
) (
   input logic        CLOCK,
   input logic        RESET_N,
   ex_muldiv_if.slave bus
);

   state_e            state_q, state_d;
   logic [CNT_W-1:0]  cnt_q;
   logic [2*XLEN-1:0] work_q, work_nxt_c;
   logic [XLEN-1:0]   opnd_q;
   muldiv_ctx_t       ctx_q;
   logic [XLEN-1:0]   res_q;
   logic [4:0]        rd_q;

   logic              accept, last;
   logic              sa, sb, is_div_in, hi_in, short_c;
   logic [XLEN-1:0]   mag_a, mag_b, short_res_c;
   logic [2*XLEN-1:0] full_c;
   logic [XLEN-1:0]   sel_c, final_res_c;

   muldiv_iter #(.XLEN(XLEN)) u_iter (
      .is_div     (op_is_div(ctx_q.op)),
      .opnd       (opnd_q),
      .work       (work_q),
      .work_nxt_c (work_nxt_c)
   );

   // Operand magnitudes and the zero-divisor / overflow shortcuts.
   always_comb begin
      sa          = 1'b0;
      sb          = 1'b0;
      short_c     = 1'b0;
      short_res_c = '0;
      is_div_in   = op_is_div(bus.ALU_Control);
      hi_in       = op_takes_high(bus.ALU_Control);
`ifdef MULDIV_SIGNED_EN
      if (op_is_signed(bus.ALU_Control)) begin
         sa = bus.data_1[XLEN-1];
         sb = bus.data_2[XLEN-1];
      end
`endif
      mag_a = sa ? XLEN'(-bus.data_1) : bus.data_1;
      mag_b = sb ? XLEN'(-bus.data_2) : bus.data_2;
      if (is_div_in && bus.data_2 == '0) begin
         short_c     = 1'b1;
         short_res_c = hi_in ? bus.data_1 : '1;
      end
`ifdef MULDIV_SIGNED_EN
      else if (is_div_in && sa && bus.data_1 == {1'b1, {(XLEN-1){1'b0}}} && bus.data_2 == '1) begin
         short_c     = 1'b1;
         short_res_c = hi_in ? '0 : {1'b1, {(XLEN-1){1'b0}}};
      end
`endif
   end

   // Sign fix-up applied to the final iteration's output.
   always_comb begin
      full_c = (ctx_q.neg_q && !op_is_div(ctx_q.op)) ? -work_nxt_c : work_nxt_c;
      sel_c  = op_takes_high(ctx_q.op) ? full_c[2*XLEN-1:XLEN] : full_c[XLEN-1:0];
      if (op_is_div(ctx_q.op) && (op_takes_high(ctx_q.op) ? ctx_q.neg_r : ctx_q.neg_q))
         final_res_c = -sel_c;
      else
         final_res_c = sel_c;
   end

   always_ff @(posedge CLOCK or negedge RESET_N) begin
      if (!RESET_N) state_q <= ST_IDLE;
      else          state_q <= state_d;
   end

   always_comb begin
      state_d       = state_q;
      accept        = 1'b0;
      last          = 1'b0;
      bus.in_ready  = 1'b0;
      bus.stall     = 1'b0;
      bus.out_valid = 1'b0;
      unique case (state_q)
         ST_IDLE: begin
            bus.in_ready = 1'b1;
            if (!bus.flush && bus.in_valid && op_supported(bus.ALU_Control)) begin
               accept  = 1'b1;
               state_d = short_c ? ST_DONE : ST_BUSY;
            end
         end
         ST_BUSY: begin
            bus.stall = 1'b1;
            if (bus.flush) begin
               state_d = ST_IDLE;
            end else if (cnt_q == CNT_W'(XLEN-1)) begin
               last    = 1'b1;
               state_d = ST_DONE;
            end
         end
         ST_DONE: begin
            bus.stall     = 1'b1;
            bus.out_valid = 1'b1;
            if (bus.flush || bus.out_ready) state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // Datapath: latch on accept, iterate while busy, capture result entering DONE.
   always_ff @(posedge CLOCK or negedge RESET_N) begin
      if (!RESET_N) begin
         cnt_q  <= '0;
         work_q <= '0;
         opnd_q <= '0;
         ctx_q  <= '0;
         res_q  <= '0;
         rd_q   <= '0;
      end else if (accept) begin
         cnt_q       <= '0;
         ctx_q.op    <= bus.ALU_Control;
         ctx_q.rd    <= bus.RD;
         ctx_q.neg_q <= sa ^ sb;
         ctx_q.neg_r <= sa;
         opnd_q      <= is_div_in ? mag_b : mag_a;
         work_q      <= {{XLEN{1'b0}}, (is_div_in ? mag_a : mag_b)};
         if (short_c) begin
            res_q <= short_res_c;
            rd_q  <= bus.RD;
         end
      end else if (state_q == ST_BUSY && !bus.flush) begin
         work_q <= work_nxt_c;
         cnt_q  <= cnt_q + CNT_W'(1);
         if (last) begin
            res_q <= final_res_c;
            rd_q  <= ctx_q.rd;
         end
      end
   end

   assign bus.out_result = res_q;
   assign bus.out_RD     = rd_q;

endmodule

// File: tb/tb_ex_muldiv.sv
// Directed plus random checks of ex_muldiv against an arithmetic reference model.
module tb_ex_muldiv;
   import ex_muldiv_pkg::*;

   localparam int unsigned XLEN = 32;
   localparam logic [31:0] MINV = 32'h8000_0000;

   logic CLOCK   = 1'b0;
   logic RESET_N = 1'b0;

   ex_muldiv_if #(.XLEN(XLEN)) bus ();

   ex_muldiv #(.XLEN(XLEN)) dut (
      .CLOCK   (CLOCK),
      .RESET_N (RESET_N),
      .bus     (bus)
   );

   always #5 CLOCK = ~CLOCK;

   int vectors     = 0;
   int miscompares = 0;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] ref_result(input logic [4:0] op, input logic [31:0] a,
                                              input logic [31:0] b);
      logic [63:0]        p;
      logic signed [63:0] sp;
      p  = {32'b0, a} * {32'b0, b};
      sp = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
      case (op)
         OP_MUL:   return p[31:0];
         OP_MULHU: return p[63:32];
         OP_DIVU:  return (b == 0) ? 32'hFFFF_FFFF : a / b;
         OP_REMU:  return (b == 0) ? a : a % b;
         OP_MULH:  return sp[63:32];
         OP_DIV: begin
            if (b == 0) return 32'hFFFF_FFFF;
            if (a == MINV && b == 32'hFFFF_FFFF) return MINV;
            return 32'($signed(a) / $signed(b));
         end
         OP_REM: begin
            if (b == 0) return a;
            if (a == MINV && b == 32'hFFFF_FFFF) return 32'h0;
            return 32'($signed(a) % $signed(b));
         end
         default: return 32'h0;
      endcase
   endfunction

   function automatic int ref_latency(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
      if (op inside {OP_DIVU, OP_REMU, OP_DIV, OP_REM} && b == 0) return 1;
      if (op inside {OP_DIV, OP_REM} && a == MINV && b == 32'hFFFF_FFFF) return 1;
      return XLEN + 1;
   endfunction

   task automatic tick();
      @(posedge CLOCK);
      #1;
   endtask

   // Issue one request, wait for the result, hold it for `hold` cycles, then take it.
   task automatic run_op(input string tag, input logic [4:0] op, input logic [31:0] a,
                         input logic [31:0] b, input logic [4:0] rd, input int hold);
      logic [31:0] exp_res;
      int          exp_lat, cycles;
      logic        stall_ok, stable;
      exp_res = ref_result(op, a, b);
      exp_lat = ref_latency(op, a, b);
      bus.in_valid    = 1'b1;
      bus.ALU_Control = op;
      bus.data_1      = a;
      bus.data_2      = b;
      bus.RD          = rd;
      bus.out_ready   = 1'b0;
      check({tag, ".in_ready"}, 64'(bus.in_ready), 64'd1);
      tick();
      bus.in_valid = 1'b0;
      bus.data_1   = $urandom;
      bus.data_2   = $urandom;
      bus.RD       = 5'($urandom);
      cycles   = 1;
      stall_ok = 1'b1;
      while (!bus.out_valid && cycles < 100) begin
         if (!bus.stall || bus.in_ready) stall_ok = 1'b0;
         tick();
         cycles++;
      end
      check({tag, ".latency"}, 64'(cycles), 64'(exp_lat));
      check({tag, ".stall_busy"}, 64'(stall_ok), 64'd1);
      check({tag, ".result"}, 64'(bus.out_result), 64'(exp_res));
      check({tag, ".rd"}, 64'(bus.out_RD), 64'(rd));
      stable = bus.stall & ~bus.in_ready;
      for (int i = 0; i < hold; i++) begin
         tick();
         if (!bus.out_valid || !bus.stall || bus.in_ready ||
             bus.out_result !== exp_res || bus.out_RD !== rd) stable = 1'b0;
      end
      check({tag, ".done_stable"}, 64'(stable), 64'd1);
      bus.out_ready = 1'b1;
      tick();
      bus.out_ready = 1'b0;
      check({tag, ".after_take"}, {61'd0, bus.out_valid, bus.in_ready, bus.stall}, {61'd0, 3'b010});
   endtask

   initial begin
      logic [4:0]  ops[$];
      logic [4:0]  op;
      logic [31:0] a, b;
      logic        seen;

      bus.in_valid    = 1'b0;
      bus.data_1      = '0;
      bus.data_2      = '0;
      bus.RD          = '0;
      bus.ALU_Control = '0;
      bus.flush       = 1'b0;
      bus.out_ready   = 1'b0;

      // Reset values
      #12;
      check("reset.ctrl", {61'd0, bus.in_ready, bus.stall, bus.out_valid}, {61'd0, 3'b100});
      check("reset.result", 64'(bus.out_result), 64'd0);
      check("reset.rd", 64'(bus.out_RD), 64'd0);
      @(negedge CLOCK);
      RESET_N = 1'b1;
      tick();

      // Directed arithmetic
      run_op("mul_7x6", OP_MUL, 32'd7, 32'd6, 5'd5, 0);
      run_op("mulhu_ff", OP_MULHU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd1, 0);
      run_op("mul_ff", OP_MUL, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd2, 0);
      run_op("divu_100_7", OP_DIVU, 32'd100, 32'd7, 5'd3, 0);
      run_op("remu_100_7", OP_REMU, 32'd100, 32'd7, 5'd4, 0);
      run_op("divu_by0", OP_DIVU, 32'd123, 32'd0, 5'd6, 0);
      run_op("remu_by0", OP_REMU, 32'd123, 32'd0, 5'd7, 0);
      run_op("backpressure", OP_MUL, 32'd1234, 32'd5678, 5'd9, 5);

      // Flush during BUSY
      bus.in_valid = 1'b1; bus.ALU_Control = OP_MUL; bus.data_1 = 32'd3; bus.data_2 = 32'd4; bus.RD = 5'd8;
      tick();
      bus.in_valid = 1'b0;
      repeat (9) tick();
      bus.flush = 1'b1;
      tick();
      bus.flush = 1'b0;
      check("flush_busy.ctrl", {61'd0, bus.in_ready, bus.stall, bus.out_valid}, {61'd0, 3'b100});
      seen = 1'b0;
      repeat (40) begin tick(); if (bus.out_valid) seen = 1'b1; end
      check("flush_busy.no_result", 64'(seen), 64'd0);

      // Flush while the result is waiting
      bus.in_valid = 1'b1; bus.ALU_Control = OP_DIVU; bus.data_1 = 32'd9; bus.data_2 = 32'd0; bus.RD = 5'd10;
      tick();
      bus.in_valid = 1'b0;
      check("flush_done.valid_before", 64'(bus.out_valid), 64'd1);
      bus.flush = 1'b1;
      tick();
      bus.flush = 1'b0;
      check("flush_done.ctrl", {61'd0, bus.in_ready, bus.stall, bus.out_valid}, {61'd0, 3'b100});

      // Flush beats accept in IDLE; unsupported codes are ignored
      bus.in_valid = 1'b1; bus.flush = 1'b1; bus.ALU_Control = OP_MUL;
      tick();
      bus.flush = 1'b0; bus.in_valid = 1'b0;
      check("flush_idle.ctrl", {61'd0, bus.in_ready, bus.stall, bus.out_valid}, {61'd0, 3'b100});
      bus.in_valid = 1'b1; bus.ALU_Control = 5'h00;
      tick();
`ifndef MULDIV_SIGNED_EN
      bus.ALU_Control = OP_DIV;
      tick();
`endif
      bus.in_valid = 1'b0;
      seen = 1'b0;
      repeat (3) begin if (!bus.in_ready || bus.stall || bus.out_valid) seen = 1'b1; tick(); end
      check("unsupported.idle", 64'(seen), 64'd0);

      // Reset in the middle of BUSY
      bus.in_valid = 1'b1; bus.ALU_Control = OP_MUL; bus.data_1 = 32'd11; bus.data_2 = 32'd13; bus.RD = 5'd12;
      tick();
      bus.in_valid = 1'b0;
      repeat (5) tick();
      RESET_N = 1'b0;
      #1;
      check("reset_mid.ctrl", {61'd0, bus.in_ready, bus.stall, bus.out_valid}, {61'd0, 3'b100});
      check("reset_mid.outs", {27'd0, bus.out_RD, bus.out_result}, 64'd0);
      @(negedge CLOCK);
      RESET_N = 1'b1;
      tick();
      run_op("after_reset", OP_MULHU, 32'h8000_0000, 32'd4, 5'd13, 0);

`ifdef MULDIV_SIGNED_EN
      run_op("div_m7_2", OP_DIV, 32'hFFFF_FFF9, 32'd2, 5'd14, 0);
      run_op("rem_m7_2", OP_REM, 32'hFFFF_FFF9, 32'd2, 5'd15, 0);
      run_op("div_ovf", OP_DIV, MINV, 32'hFFFF_FFFF, 5'd16, 0);
      run_op("rem_ovf", OP_REM, MINV, 32'hFFFF_FFFF, 5'd17, 0);
      run_op("div_by0_s", OP_DIV, 32'hFFFF_FF00, 32'd0, 5'd18, 0);
      run_op("mulh_neg", OP_MULH, 32'hFFFF_FFFF, 32'd5, 5'd19, 0);
      ops = '{OP_MUL, OP_MULHU, OP_DIVU, OP_REMU, OP_MULH, OP_DIV, OP_REM};
`else
      ops = '{OP_MUL, OP_MULHU, OP_DIVU, OP_REMU};
`endif

      // Randomized operations
      for (int n = 0; n < 24; n++) begin
         op = ops[$urandom_range(0, ops.size() - 1)];
         a  = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 255)) : $urandom;
         b  = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 15))  : $urandom;
         if ($urandom_range(0, 7) == 0) b = $urandom >> $urandom_range(0, 31);
         run_op($sformatf("rand%0d", n), op, a, b, 5'($urandom), $urandom_range(0, 3));
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/ex_muldiv.md
Name: ex_muldiv

Overview:
- Multi-cycle integer multiply/divide unit in the EX stage.
- Consumes the operand, destination and ALU-op fields that the ID/EX pipeline register presents.
- Drives a stall back to decode while iterating, then hands a result plus destination register to the EX/MEM path.
- Handles the operations the single-cycle ALU cannot.

Parameters:
- XLEN, 32, operand and result width.
- CNT_W, 6, iteration counter width; must satisfy 2^CNT_W > XLEN.

Ports:
- CLOCK  input  1  rising-edge clock.
- RESET_N  input  1  asynchronous active-low reset.
- in_valid  input  1  request present on data_1/data_2/RD/ALU_Control.
- in_ready  output  1  unit can accept a request this cycle.
- data_1  input  XLEN  operand A: multiplicand or dividend.
- data_2  input  XLEN  operand B: multiplier or divisor.
- RD  input  5  destination register.
- ALU_Control  input  5  operation code.
- flush  input  1  abort the current operation (branch mispredict).
- stall  output  1  freeze IF/ID/ID_EX.
- out_valid  output  1  result available.
- out_ready  input  1  downstream accepts the result.
- out_result  output  XLEN  result.
- out_RD  output  5  destination register of the result.

Behaviour:
- Reset (async, RESET_N low):
  - State IDLE; all outputs 0 except in_ready=1.
  - Internal accumulators and counter cleared.
- Op codes:
  - 5'h10 MUL: low XLEN bits of A*B.
  - 5'h11 MULHU: high XLEN bits, unsigned.
  - 5'h12 DIVU: unsigned quotient.
  - 5'h13 REMU: unsigned remainder.
- A request is accepted on an edge where in_valid & in_ready and ALU_Control is a supported code.
  - Unsupported codes are ignored: no state change, no result.
- State IDLE:
  - in_ready=1, stall=0.
  - On accept: latch the operands, RD and op; counter=0; go to BUSY.
  - Divide with data_2==0 goes straight to DONE with quotient=all ones and remainder=data_1.
- State BUSY:
  - in_ready=0, stall=1.
  - One iteration per cycle: shift-add multiply or restoring divide on a 2*XLEN working register.
  - After XLEN iterations (counter==XLEN-1 at the edge), go to DONE.
- State DONE:
  - out_valid=1 and stall=1.
  - out_result and out_RD stay stable until out_ready.
  - On out_valid & out_ready: go to IDLE; out_valid drops next cycle.
  - No back-to-back accept in the same cycle the result is taken: in_ready=0 in DONE.
- Latency:
  - Accept edge at cycle 0; out_valid high from cycle XLEN+1 (33 at the default).
  - Divide by zero: out_valid high at cycle 1.
- Stall timing: stall is combinational from the state, so it is high in the cycle after accept.
  - Decode must hold the instruction following the mul/div.
- flush:
  - In BUSY or DONE: return to IDLE on the next edge; out_valid is never asserted, or is dropped if already asserted.
  - In IDLE: flush has priority over accept, so the request is dropped.
- Reset mid-operation aborts immediately; no result is produced.
- All arithmetic is modulo 2^XLEN for the low word; the high word comes from the full 2*XLEN product.

Optional Feature:
- Macro MULDIV_SIGNED_EN.
- When defined, adds the signed codes:
  - 5'h14 MULH
  - 5'h15 DIV
  - 5'h16 REM
- Signed handling:
  - Operands are converted to magnitude on accept.
  - Result sign is fixed in the DONE transition; quotient sign = sA^sB, remainder sign = sA.
  - Overflow case (most negative / -1): quotient = most negative, remainder = 0, one-cycle DONE.
  - Signed divide by zero: quotient = all ones, remainder = dividend.
- When undefined, 5'h14–5'h16 are unsupported codes and are ignored.

Decomposition:
- Package ex_muldiv_pkg holds:
  - op code localparams: OP_MUL, OP_MULHU, OP_DIVU, OP_REMU, OP_MULH, OP_DIV, OP_REM;
  - state encoding: ST_IDLE, ST_BUSY, ST_DONE;
  - XLEN default.
- One natural sub-module, muldiv_iter:
  - the per-cycle datapath step (shift-add or restore-subtract on the working register);
  - the FSM and handshakes stay in the top level.

Test Plan:
- MUL: A=7, B=6, RD=5 -> out_valid at cycle 33, out_result=42, out_RD=5, stall high cycles 1–33.
- MULHU: A=32'hFFFF_FFFF, B=32'hFFFF_FFFF -> out_result=32'hFFFF_FFFE; MUL of the same operands -> 32'h0000_0001.
- DIVU/REMU: A=100, B=7 -> quotient 14, remainder 2.
- DIVU: A=123, B=0 -> out_valid at cycle 1 with 32'hFFFF_FFFF; REMU -> 123.
- Backpressure and flush:
  - out_ready held low 5 cycles after DONE -> result and RD stable, stall high throughout.
  - flush at cycle 10 of BUSY -> IDLE next edge, no out_valid, in_ready=1.
- Reset and signed: RESET_N low mid-BUSY -> outputs 0, in_ready=1. With MULDIV_SIGNED_EN:
  - DIV -7/2 -> -3;
  - REM -7/2 -> -1;
  - DIV 32'h8000_0000 / -1 -> 32'h8000_0000.
